// File: rtl/bn_down_counter.sv
// bn_down_counter: one cascadable modulo-MOD down-counter digit.
// A stage's ei is driven by the previous stage's eu, so eu carries the borrow
// to the next, more significant digit. A parallel load saturates any d >= MOD
// to MOD-1.
// Optional build macro BN_DOWN_COUNTER_UF_FLAG_EN adds a sticky underflow flag
// (uf) and its acknowledge input (uf_ack).
module bn_down_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MOD = 16
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         ei,
  input  logic         load,
  input  logic [W-1:0] d,
`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
  input  logic         uf_ack,
  output logic         uf,
`endif
  output logic         eu,
  output logic [W-1:0] q,
  output logic         zero
);

  localparam int unsigned WE = W + 1;
  // Highest reachable count; for MOD == 2^W this equals the W-bit all-ones value.
  localparam logic [W-1:0]  QMax   = W'(MOD - 1);
  // Modulus widened by one bit so MOD == 2^W stays representable in the compare.
  localparam logic [WE-1:0] ModExt = WE'(MOD);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         q_is_zero;

  assign q_is_zero = (q_q == '0);

  // Borrow-out: a decrement request at zero, suppressed by load and by reset.
  assign eu   = reset_ & ei & ~load & q_is_zero;
  assign zero = q_is_zero;
  assign q    = q_q;

  // Next count: load (with saturation) beats decrement; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = ({1'b0, d} >= ModExt) ? QMax : d;
    end else if (ei) begin
      q_d = q_is_zero ? QMax : (q_q - W'(1));
    end
  end

  // Count register; asynchronous clear to zero.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_FLAGGED = 1'b1
  } uf_state_e;

  uf_state_e state_q;
  uf_state_e state_d;

  // Flag FSM: set on any borrow-out; an ack clears it unless a new borrow lands in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (eu) begin
          state_d = ST_FLAGGED;
        end
      end
      ST_FLAGGED: begin
        if (uf_ack && !eu) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag state register; reset returns to IDLE.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign uf = (state_q == ST_FLAGGED);
`endif

endmodule

// File: tb/tb_bn_down_counter.sv
// Bench for bn_down_counter: one MOD=10 digit plus a 4-digit MOD=16 chain.
module tb_bn_down_counter;

  logic clock  = 1'b0;
  logic reset_ = 1'b1;

  // Single decimal digit
  logic       ei10  = 1'b0;
  logic       ld10  = 1'b0;
  logic       ack10 = 1'b0;
  logic [3:0] d10   = 4'd0;
  logic       eu10;
  logic       zero10;
  logic [3:0] q10;
`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
  logic       uf10;
  logic [3:0] ch_uf;
`endif

  // 4-digit MOD=16 chain
  logic       c_e0 = 1'b0;
  logic [3:0] ch_ei;
  logic [3:0] ch_eu;
  logic [3:0] ch_zero;
  logic [3:0] ch_q [4];

  // Reference model and scoreboard
  logic [3:0]  mq;
  logic        muf;
  logic [15:0] cv;
  logic [31:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  bn_down_counter #(.W(4), .MOD(10)) u_m10 (
    .clock  (clock),
    .reset_ (reset_),
    .ei     (ei10),
    .load   (ld10),
    .d      (d10),
`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
    .uf_ack (ack10),
    .uf     (uf10),
`endif
    .eu     (eu10),
    .q      (q10),
    .zero   (zero10)
  );

  assign ch_ei = {ch_eu[2:0], c_e0};

  for (genvar g = 0; g < 4; g++) begin : g_chain
    bn_down_counter #(.W(4), .MOD(16)) u_stage (
      .clock  (clock),
      .reset_ (reset_),
      .ei     (ch_ei[g]),
      .load   (1'b0),
      .d      (4'd0),
`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
      .uf_ack (1'b0),
      .uf     (ch_uf[g]),
`endif
      .eu     (ch_eu[g]),
      .q      (ch_q[g]),
      .zero   (ch_zero[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: combinational outputs checked before the edge,
  // registered results pushed to the scoreboard and compared after it.
  task automatic step(input logic ld, input logic [3:0] dv, input logic e,
                      input logic ack, input logic e0);
    logic        eu_exp;
    logic [3:0]  nq;
    logic        nuf;
    logic [15:0] ncv;
    logic [15:0] m;
    logic [31:0] exp;
    @(negedge clock);
    ld10 = ld; d10 = dv; ei10 = e; ack10 = ack; c_e0 = e0;
    #1;
    eu_exp = e && !ld && (mq == 4'd0);
    check("eu10", 32'(eu10), 32'(eu_exp));
    check("zero10", 32'(zero10), 32'(mq == 4'd0));
    for (int k = 0; k < 4; k++) begin
      m = 16'hFFFF >> (4 * (3 - k));
      check($sformatf("ch_eu%0d", k), 32'(ch_eu[k]), 32'(e0 && ((cv & m) == 16'd0)));
      check($sformatf("ch_zero%0d", k), 32'(ch_zero[k]), 32'(cv[4*k +: 4] == 4'd0));
    end
    if (ld)     nq = (dv >= 4'd10) ? 4'd9 : dv;
    else if (e) nq = (mq == 4'd0) ? 4'd9 : mq - 4'd1;
    else        nq = mq;
    nuf = muf ? !(ack && !eu_exp) : eu_exp;
    ncv = e0 ? cv - 16'd1 : cv;
    sb_q.push_back({ncv, 11'd0, nuf, nq});
    mq = nq; muf = nuf; cv = ncv;
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check("q10", 32'(q10), 32'(exp[3:0]));
`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
      check("uf10", 32'(uf10), 32'(exp[4]));
`endif
      check("chain_q", 32'({ch_q[3], ch_q[2], ch_q[1], ch_q[0]}), 32'(exp[31:16]));
    end
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_q10"}, 32'(q10), 32'd0);
    check({tag, "_eu10"}, 32'(eu10), 32'd0);
    check({tag, "_zero10"}, 32'(zero10), 32'd1);
    check({tag, "_chq"}, 32'({ch_q[3], ch_q[2], ch_q[1], ch_q[0]}), 32'd0);
    check({tag, "_cheu"}, 32'(ch_eu), 32'd0);
`ifdef BN_DOWN_COUNTER_UF_FLAG_EN
    check({tag, "_uf10"}, 32'(uf10), 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mq = 4'd0; muf = 1'b0; cv = 16'd0;
    // Asynchronous reset with decrement requested, before and across an edge
    #1;
    reset_ = 1'b0; ei10 = 1'b1; c_e0 = 1'b1;
    #2;
    check_in_reset("rst_async");
    @(posedge clock);
    #1;
    check_in_reset("rst_hold");
    @(negedge clock);
    ei10 = 1'b0; c_e0 = 1'b0;
    reset_ = 1'b1;

    // Full-chain underflow ripples in one cycle: 0000 -> FFFF
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    // Load beats decrement at zero: no borrow, q=7
    step(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    // Load 3 then count 2,1,0,9,8 with borrow only at 0
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    // Clamp out-of-range loads
    step(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    // Reset mid-count at q=5, released before the next rising edge
    @(negedge clock);
    #2;
    reset_ = 1'b0; ei10 = 1'b1; ld10 = 1'b0; ack10 = 1'b0; c_e0 = 1'b0;
    #1;
    check_in_reset("rst_mid");
    ei10 = 1'b0;
    #1;
    reset_ = 1'b1;
    mq = 4'd0; muf = 1'b0; cv = 16'd0;

    // Underflow flag set, ack colliding with a new borrow, then plain ack
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Random mix of all controls
    repeat (80) begin
      step(1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
